kbd_rx_buffer: RTL and testbench

KBD_RX_BUFFER -- requirements
Module: kbd_rx_buffer

---
 rtl/kbd_rx_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_kbd_rx_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_rx_buffer.sv
// ---------------------------------------------------------------------------
// kbd_rx_buffer
//
// Receive buffer between a PS/2 key decoder and a 64-bit CPU bus. Each new
// key press (rising edge of key_pressed with a non-zero ascii_code) is pushed
// into a DEPTH-entry byte FIFO. The CPU pops bytes from the data register at
// KEY_BASE and reads or controls the buffer through the status register at
// KEY_BASE+8. A three-state interrupt FSM raises VECTOR while unread data is
// waiting and the CPU has not yet acknowledged it.
//
// DEPTH must be a power of two in the range 2..128 so that the pointers wrap
// naturally and the count fits in the 8-bit status field.
//
// Ports
//   clk               in   system clock, all state on its rising edge
//   reset             in   synchronous, active-high reset
//   key_pressed       in   level from the PS/2 decoder, high while a key is held
//   ascii_code  [7:0] in   decoded character, valid while key_pressed is high
//   bus_address [63:0] in  CPU byte address
//   bus_read_enable   in   CPU read strobe
//   bus_write_enable  in   CPU write strobe
//   bus_write_data [63:0] in CPU write data
//   bus_read_data  [63:0] out registered read data (1-cycle latency)
//   interrupt_vector [3:0] out 0 = none, VECTOR = keyboard data pending
//   interrupt_ack     in   CPU acknowledge of the current vector
//   overflow          out  sticky: a key was dropped because the FIFO was full
//
// Status register layout: [10] overflow, [9] full, [8] empty, [7:0] count.
// Status write: bit 0 clears overflow, bit 1 flushes the FIFO.
// ---------------------------------------------------------------------------
module kbd_rx_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [63:0] KEY_BASE = 64'h0000_0000_0000_2010,
    parameter logic [3:0]  VECTOR   = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_pressed,
    input  logic [7:0]  ascii_code,
    input  logic [63:0] bus_address,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    input  logic [63:0] bus_write_data,
    output logic [63:0] bus_read_data,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_ack,
    output logic        overflow
);

    localparam int unsigned    PTR_W       = $clog2(DEPTH);
    localparam int unsigned    CNT_W       = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [63:0]    STATUS_ADDR = KEY_BASE + 64'd8;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_ASSERT,
        IRQ_ACKED
    } irq_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]        mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              key_pressed_q, key_pressed_d;
    logic              data_rd_q, data_rd_d;
    logic              status_rd_q, status_rd_d;
    logic              status_wr_q, status_wr_d;
    logic [63:0]       bus_read_data_q, bus_read_data_d;
    irq_state_e        irq_state_q, irq_state_d;
    logic [3:0]        interrupt_vector_q, interrupt_vector_d;

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic data_rd_hit, status_rd_hit, status_wr_hit;
    logic push_ev, pop_ev, status_rd_ev, status_wr_ev;
    logic empty, full, flush, clear_ovf;
    logic do_push, do_pop, push_drop;
    logic [63:0] status_word;
    logic unused_wdata;

    assign data_rd_hit   = bus_read_enable  && (bus_address == KEY_BASE);
    assign status_rd_hit = bus_read_enable  && (bus_address == STATUS_ADDR);
    assign status_wr_hit = bus_write_enable && (bus_address == STATUS_ADDR);

    // Strobes are edge-detected so a long CPU strobe acts only once.
    assign push_ev      = key_pressed && !key_pressed_q && (ascii_code != 8'd0);
    assign pop_ev       = data_rd_hit   && !data_rd_q;
    assign status_rd_ev = status_rd_hit && !status_rd_q;
    assign status_wr_ev = status_wr_hit && !status_wr_q;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign flush     = status_wr_ev && bus_write_data[1];
    assign clear_ovf = status_wr_ev && bus_write_data[0];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the
    // push. A flush discards any concurrent push outright.
    assign do_pop    = pop_ev && !empty;
    assign do_push   = push_ev && !flush && (!full || do_pop);
    assign push_drop = push_ev && !flush && full && !do_pop;

    assign status_word  = {53'd0, overflow_q, full, empty, 8'(count_q)};
    assign unused_wdata = ^bus_write_data[63:2];

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        key_pressed_d   = key_pressed;
        data_rd_d       = data_rd_hit;
        status_rd_d     = status_rd_hit;
        status_wr_d     = status_wr_hit;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        bus_read_data_d = bus_read_data_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Drop wins over a clear in the same cycle: the loss is more recent.
        overflow_d = (overflow_q && !clear_ovf) || push_drop;

        // Empty pops read zero; a same-cycle push is not bypassed.
        if (pop_ev) begin
            bus_read_data_d = empty ? 64'd0 : {56'd0, mem[rd_ptr_q]};
        end else if (status_rd_ev) begin
            bus_read_data_d = status_word;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        irq_state_d = irq_state_q;
        case (irq_state_q)
            IRQ_IDLE:   if (!empty)        irq_state_d = IRQ_ASSERT;
            IRQ_ASSERT: if (interrupt_ack) irq_state_d = IRQ_ACKED;
            IRQ_ACKED: begin
                if (do_push)    irq_state_d = IRQ_ASSERT;
                else if (empty) irq_state_d = IRQ_IDLE;
            end
            default:            irq_state_d = IRQ_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Interrupt FSM: output (registered from the next state)
    // ------------------------------------------------------------------
    always_comb begin
        interrupt_vector_d = (irq_state_d == IRQ_ASSERT) ? VECTOR : 4'd0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            count_q            <= '0;
            overflow_q         <= 1'b0;
            // Starts high so a key held through reset is not seen as a new press.
            key_pressed_q      <= 1'b1;
            data_rd_q          <= 1'b0;
            status_rd_q        <= 1'b0;
            status_wr_q        <= 1'b0;
            bus_read_data_q    <= '0;
            irq_state_q        <= IRQ_IDLE;
            interrupt_vector_q <= 4'd0;
        end else begin
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            overflow_q         <= overflow_d;
            key_pressed_q      <= key_pressed_d;
            data_rd_q          <= data_rd_d;
            status_rd_q        <= status_rd_d;
            status_wr_q        <= status_wr_d;
            bus_read_data_q    <= bus_read_data_d;
            irq_state_q        <= irq_state_d;
            interrupt_vector_q <= interrupt_vector_d;
        end
    end

    // NOTE: the storage array is not reset; count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= ascii_code;
    end

    assign bus_read_data    = bus_read_data_q;
    assign interrupt_vector = interrupt_vector_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_kbd_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_kbd_rx_buffer
//
// Directed bench for kbd_rx_buffer with DEPTH=8. Inputs are driven and
// outputs sampled on the falling clock edge; each bus access task leaves the
// strobe low for one cycle afterwards so the next access is a fresh edge.
// ---------------------------------------------------------------------------
module tb_kbd_rx_buffer;

    localparam int unsigned DEPTH    = 8;
    localparam logic [63:0] KEY_BASE = 64'h0000_0000_0000_2010;
    localparam logic [63:0] STATUS   = KEY_BASE + 64'd8;
    localparam logic [3:0]  VECTOR   = 4'd1;

    logic        clk;
    logic        reset;
    logic        key_pressed;
    logic [7:0]  ascii_code;
    logic [63:0] bus_address;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [63:0] bus_write_data;
    logic [63:0] bus_read_data;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    kbd_rx_buffer #(
        .DEPTH    (DEPTH),
        .KEY_BASE (KEY_BASE),
        .VECTOR   (VECTOR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .key_pressed      (key_pressed),
        .ascii_code       (ascii_code),
        .bus_address      (bus_address),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_write_data   (bus_write_data),
        .bus_read_data    (bus_read_data),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on run time in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_key(input logic [7:0] b);
        key_pressed = 1'b1;
        ascii_code  = b;
        tick();
        key_pressed = 1'b0;
        ascii_code  = 8'd0;
        tick();
    endtask

    task automatic bus_read(input logic [63:0] addr, output logic [63:0] d);
        bus_read_enable = 1'b1;
        bus_address     = addr;
        tick();
        d               = bus_read_data;
        bus_read_enable = 1'b0;
        bus_address     = 64'd0;
        tick();
    endtask

    task automatic bus_write(input logic [63:0] addr, input logic [63:0] wd);
        bus_write_enable = 1'b1;
        bus_address      = addr;
        bus_write_data   = wd;
        tick();
        bus_write_enable = 1'b0;
        bus_address      = 64'd0;
        bus_write_data   = 64'd0;
        tick();
    endtask

    task automatic pulse_ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    logic [63:0] rd;
    logic [7:0]  exp_bytes [8];

    initial begin
        reset            = 1'b1;
        key_pressed      = 1'b0;
        ascii_code       = 8'd0;
        bus_address      = 64'd0;
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        bus_write_data   = 64'd0;
        interrupt_ack    = 1'b0;
        do_reset();

        // Reset state
        check("reset_rdata", bus_read_data, 64'd0);
        check("reset_vector", interrupt_vector, 64'd0);
        check("reset_overflow", overflow, 64'd0);
        bus_read(STATUS, rd);
        check("reset_status", rd, 64'h100);

        // Single key 'A': interrupt at push+2, read back, status empty
        key_pressed = 1'b1;
        ascii_code  = 8'h41;
        tick();
        check("irq_push+1_low", interrupt_vector, 64'd0);
        key_pressed = 1'b0;
        ascii_code  = 8'd0;
        tick();
        check("irq_push+2_high", interrupt_vector, 64'(VECTOR));
        tick();
        tick();
        bus_read(KEY_BASE, rd);
        check("read_A", rd, 64'h41);
        bus_read(STATUS, rd);
        check("status_after_A", rd, 64'h100);

        // Nine keys into eight entries: one dropped, sticky overflow
        do_reset();
        for (int i = 1; i <= 9; i++) push_key(8'(i));
        check("overflow_set", overflow, 64'd1);
        bus_read(STATUS, rd);
        check("status_full_ovf", rd, 64'h608);
        for (int i = 1; i <= 8; i++) begin
            bus_read(KEY_BASE, rd);
            check($sformatf("drain_%0d", i), rd, 64'(i));
        end
        bus_read(KEY_BASE, rd);
        check("read_empty_zero", rd, 64'd0);
        bus_read(STATUS, rd);
        check("status_drained_ovf", rd, 64'h500);

        // Long read strobe pops exactly once
        do_reset();
        push_key(8'h11);
        push_key(8'h22);
        push_key(8'h33);
        bus_read_enable = 1'b1;
        bus_address     = KEY_BASE;
        repeat (20) tick();
        check("held_read_data", bus_read_data, 64'h11);
        bus_read_enable = 1'b0;
        bus_address     = 64'd0;
        tick();
        bus_read(STATUS, rd);
        check("held_read_count", rd, 64'h002);
        bus_read(KEY_BASE, rd);
        check("held_read_next", rd, 64'h22);

        // Full FIFO: push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 8; i++) push_key(8'hA0 + 8'(i));
        key_pressed     = 1'b1;
        ascii_code      = 8'hB0;
        bus_read_enable = 1'b1;
        bus_address     = KEY_BASE;
        tick();
        check("full_pushpop_oldest", bus_read_data, 64'hA0);
        key_pressed     = 1'b0;
        ascii_code      = 8'd0;
        bus_read_enable = 1'b0;
        bus_address     = 64'd0;
        tick();
        check("full_pushpop_noovf", overflow, 64'd0);
        bus_read(STATUS, rd);
        check("full_pushpop_status", rd, 64'h208);
        for (int i = 0; i < 7; i++) exp_bytes[i] = 8'hA1 + 8'(i);
        exp_bytes[7] = 8'hB0;
        for (int i = 0; i < 8; i++) begin
            bus_read(KEY_BASE, rd);
            check($sformatf("full_drain_%0d", i), rd, 64'(exp_bytes[i]));
        end

        // Interrupt FSM: assert, ack, re-assert on new push, return to idle
        do_reset();
        push_key(8'h51);
        push_key(8'h52);
        check("irq_asserted", interrupt_vector, 64'(VECTOR));
        pulse_ack();
        check("irq_dropped_after_ack", interrupt_vector, 64'd0);
        repeat (4) tick();
        check("irq_stays_low", interrupt_vector, 64'd0);
        push_key(8'h53);
        check("irq_reasserted", interrupt_vector, 64'(VECTOR));
        pulse_ack();
        check("irq_dropped_again", interrupt_vector, 64'd0);
        tick();
        bus_read(KEY_BASE, rd);
        check("irq_drain_0", rd, 64'h51);
        bus_read(KEY_BASE, rd);
        check("irq_drain_1", rd, 64'h52);
        bus_read(KEY_BASE, rd);
        check("irq_drain_2", rd, 64'h53);
        check("irq_low_when_empty", interrupt_vector, 64'd0);
        // From idle the vector needs two cycles; from the acked state only one.
        key_pressed = 1'b1;
        ascii_code  = 8'h54;
        tick();
        check("irq_idle_push+1_low", interrupt_vector, 64'd0);
        key_pressed = 1'b0;
        ascii_code  = 8'd0;
        tick();
        check("irq_idle_push+2_high", interrupt_vector, 64'(VECTOR));

        // Status write: clear overflow and flush; write to data reg ignored
        do_reset();
        for (int i = 0; i < 9; i++) push_key(8'h21 + 8'(i));
        for (int i = 0; i < 3; i++) bus_read(KEY_BASE, rd);
        bus_read(STATUS, rd);
        check("five_with_ovf", rd, 64'h405);
        bus_write(KEY_BASE, 64'h3);
        bus_read(STATUS, rd);
        check("data_write_ignored", rd, 64'h405);
        bus_write(STATUS, 64'h3);
        bus_read(STATUS, rd);
        check("flush_clear_status", rd, 64'h100);
        check("flush_clear_ovf", overflow, 64'd0);
        push_key(8'h00);
        bus_read(STATUS, rd);
        check("zero_code_ignored", rd, 64'h100);
        bus_read(KEY_BASE + 64'd16, rd);
        check("other_addr_holds", rd, 64'h100);

        // Reset with a key held: pending data and interrupt discarded,
        // held key not captured until released and pressed again
        push_key(8'h61);
        push_key(8'h62);
        key_pressed = 1'b1;
        ascii_code  = 8'h77;
        tick();
        reset = 1'b1;
        tick();
        check("reset_clears_irq", interrupt_vector, 64'd0);
        reset = 1'b0;
        repeat (3) tick();
        bus_read(STATUS, rd);
        check("held_key_not_captured", rd, 64'h100);
        key_pressed = 1'b0;
        tick();
        key_pressed = 1'b1;
        tick();
        key_pressed = 1'b0;
        ascii_code  = 8'd0;
        tick();
        bus_read(STATUS, rd);
        check("repress_captured", rd, 64'h001);
        bus_read(KEY_BASE, rd);
        check("repress_data", rd, 64'h77);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
